// File: rtl/exanet_axis_vc_monitor.sv
// Passive AXIS packet monitor: per-VC header/payload/footer beat counters with
// snapshot-and-clear epochs, registered snapshot readout and sticky error flags.
module exanet_axis_vc_monitor #(
  parameter int unsigned NUM_VC    = 4,
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned MAX_BEATS = 16,
  localparam int unsigned VC_W     = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             mon_TVALID,
  input  logic             mon_TREADY,
  input  logic             mon_TLAST,
  input  logic [VC_W-1:0]  mon_vc,
  input  logic             snap_req,
  input  logic [VC_W-1:0]  rd_vc,
  output logic [CNT_W-1:0] rd_hdr,
  output logic [CNT_W-1:0] rd_pld,
  output logic [CNT_W-1:0] rd_ftr,
  input  logic             err_clr,
  output logic             err_len,
  output logic             err_vc,
  output logic             sat,
  output logic             in_pkt
);

  localparam logic [CNT_W-1:0] ALL1     = '1;
  localparam logic [VC_W:0]    NUM_VC_L = (VC_W+1)'(NUM_VC);
  localparam logic [8:0]       MAX_L    = 9'(MAX_BEATS);
  localparam int unsigned      K_HDR    = 0;
  localparam int unsigned      K_PLD    = 1;
  localparam int unsigned      K_FTR    = 2;

  typedef enum logic {IDLE, IN_PKT} state_t;

  state_t           state_q, state_d;
  logic [VC_W-1:0]  cur_vc_q, cur_vc_d;
  logic [7:0]       len_q, len_d;
  logic [8:0]       len_inc;
  logic             len_err_c;
  logic             vc_err_c;
  logic             sat_c;
  logic [VC_W-1:0]  cnt_vc_c;
  logic             cnt_ok_c;
  logic [2:0]       kind_c;
  logic             rd_ok_c;

  logic [CNT_W-1:0]  live_q [3][NUM_VC];
  logic [CNT_W-1:0]  snap_q [3][NUM_VC];
  logic [NUM_VC-1:0] hit_c  [3];

  // Saturating increment of one live counter.
  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && (v != ALL1)) ? v + CNT_W'(1) : v;
  endfunction

  assign len_inc = {1'b0, len_q} + 9'd1;

  // FSM next state and beat classification (header / payload / footer).
  always_comb begin
    state_d   = state_q;
    cur_vc_d  = cur_vc_q;
    len_d     = len_q;
    len_err_c = 1'b0;
    vc_err_c  = 1'b0;
    cnt_vc_c  = cur_vc_q;
    kind_c    = 3'b000;
    if (mon_TVALID && mon_TREADY) begin
      case (state_q)
        IDLE: begin
          cur_vc_d       = mon_vc;
          cnt_vc_c       = mon_vc;
          len_d          = 8'd1;
          vc_err_c       = ({1'b0, mon_vc} >= NUM_VC_L);
          kind_c[K_HDR]  = 1'b1;
          kind_c[K_FTR]  = mon_TLAST;
          if (!mon_TLAST) state_d = IN_PKT;
        end
        IN_PKT: begin
          len_err_c      = (len_inc > MAX_L);
          len_d          = (len_q == 8'hFF) ? len_q : len_inc[7:0];
          kind_c[K_PLD]  = ~mon_TLAST;
          kind_c[K_FTR]  = mon_TLAST;
          if (mon_TLAST) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cnt_ok_c = ({1'b0, cnt_vc_c} < NUM_VC_L);
  assign rd_ok_c  = ({1'b0, rd_vc} < NUM_VC_L);

  // Per-counter increment strobes and saturation detect in the live epoch.
  always_comb begin
    sat_c = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NUM_VC; i++) begin
        hit_c[k][i] = kind_c[k] & cnt_ok_c & (cnt_vc_c == VC_W'(i));
        if (hit_c[k][i] && !snap_req && (live_q[k][i] == ALL1)) sat_c = 1'b1;
      end
    end
  end

  // FSM state, current packet VC and beat count.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q  <= IDLE;
      cur_vc_q <= '0;
      len_q    <= '0;
      in_pkt   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_vc_q <= cur_vc_d;
      len_q    <= len_d;
      in_pkt   <= (state_d == IN_PKT);
    end
  end

  // Live counters; a snapshot copies them out and restarts the epoch in the same edge.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < NUM_VC; i++) begin
          live_q[k][i] <= '0;
          snap_q[k][i] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        for (int i = 0; i < NUM_VC; i++) begin
          if (snap_req) snap_q[k][i] <= live_q[k][i];
          live_q[k][i] <= bump(snap_req ? '0 : live_q[k][i], hit_c[k][i]);
        end
      end
    end
  end

  // Registered snapshot readout; out-of-range VC reads zero.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rd_hdr <= '0;
      rd_pld <= '0;
      rd_ftr <= '0;
    end else begin
      rd_hdr <= rd_ok_c ? snap_q[K_HDR][rd_vc] : '0;
      rd_pld <= rd_ok_c ? snap_q[K_PLD][rd_vc] : '0;
      rd_ftr <= rd_ok_c ? snap_q[K_FTR][rd_vc] : '0;
    end
  end

  // Sticky error flags; a set event beats a simultaneous clear.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      err_len <= 1'b0;
      err_vc  <= 1'b0;
      sat     <= 1'b0;
    end else begin
      err_len <= (err_len & ~err_clr) | len_err_c;
      err_vc  <= (err_vc  & ~err_clr) | vc_err_c;
      sat     <= (sat     & ~err_clr) | sat_c;
    end
  end

endmodule

// File: tb/tb_exanet_axis_vc_monitor.sv
// Self-checking bench for exanet_axis_vc_monitor: directed scenarios plus
// randomized packet traffic against a packet-level reference model.
module tb_exanet_axis_vc_monitor;

  localparam int unsigned NUM_VC    = 5;
  localparam int unsigned CNT_W     = 8;
  localparam int unsigned MAX_BEATS = 16;
  localparam int unsigned VC_W      = 3;
  localparam int          CMAX      = (1 << CNT_W) - 1;

  logic             ACLK = 1'b0;
  logic             ARESET;
  logic             mon_TVALID, mon_TREADY, mon_TLAST;
  logic [VC_W-1:0]  mon_vc;
  logic             snap_req;
  logic [VC_W-1:0]  rd_vc;
  logic [CNT_W-1:0] rd_hdr, rd_pld, rd_ftr;
  logic             err_clr;
  logic             err_len, err_vc, sat, in_pkt;

  exanet_axis_vc_monitor #(.NUM_VC(NUM_VC), .CNT_W(CNT_W), .MAX_BEATS(MAX_BEATS)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .mon_TVALID(mon_TVALID), .mon_TREADY(mon_TREADY), .mon_TLAST(mon_TLAST), .mon_vc(mon_vc),
    .snap_req(snap_req), .rd_vc(rd_vc),
    .rd_hdr(rd_hdr), .rd_pld(rd_pld), .rd_ftr(rd_ftr),
    .err_clr(err_clr), .err_len(err_len), .err_vc(err_vc), .sat(sat), .in_pkt(in_pkt)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: per-epoch packet statistics (kind 0 hdr, 1 pld, 2 ftr).
  int m_live [3][NUM_VC];
  int m_snap [3][NUM_VC];
  int e_rd   [3];
  bit m_open;
  int m_vc;
  int m_len;
  bit m_elen, m_evc, m_sat;

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      e_rd[k] = 0;
      for (int i = 0; i < NUM_VC; i++) begin
        m_live[k][i] = 0;
        m_snap[k][i] = 0;
      end
    end
    m_open = 0; m_vc = 0; m_len = 0;
    m_elen = 0; m_evc = 0; m_sat = 0;
  endfunction

  function automatic void m_count(input int k, input int vc);
    if (vc >= NUM_VC) return;
    if (m_live[k][vc] == CMAX) m_sat = 1;
    else m_live[k][vc]++;
  endfunction

  function automatic void model_step(input bit v, input bit r, input bit l, input int vc,
                                     input bit snap, input int rdvc, input bit clr);
    for (int k = 0; k < 3; k++) e_rd[k] = (rdvc < NUM_VC) ? m_snap[k][rdvc] : 0;
    if (clr) begin m_elen = 0; m_evc = 0; m_sat = 0; end
    if (snap) begin
      for (int k = 0; k < 3; k++)
        for (int i = 0; i < NUM_VC; i++) begin
          m_snap[k][i] = m_live[k][i];
          m_live[k][i] = 0;
        end
    end
    if (v && r) begin
      if (!m_open) begin
        m_vc  = vc;
        m_len = 1;
        if (vc >= NUM_VC) m_evc = 1;
        m_count(0, vc);
        if (l) m_count(2, vc);
        else   m_open = 1;
      end else begin
        if (m_len + 1 > MAX_BEATS) m_elen = 1;
        m_len = (m_len >= 255) ? 255 : m_len + 1;
        m_count(l ? 2 : 1, m_vc);
        if (l) m_open = 0;
      end
    end
  endfunction

  // One clock cycle of stimulus, then compare every output against the model.
  task automatic cycle(input bit v, input bit r, input bit l, input int vc,
                       input bit snap, input int rdvc, input bit clr);
    mon_TVALID = v; mon_TREADY = r; mon_TLAST = l;
    mon_vc = VC_W'(vc); snap_req = snap; rd_vc = VC_W'(rdvc); err_clr = clr;
    model_step(v, r, l, vc, snap, rdvc, clr);
    @(posedge ACLK); #1;
    check("in_pkt",  32'(in_pkt),  32'(m_open));
    check("err_len", 32'(err_len), 32'(m_elen));
    check("err_vc",  32'(err_vc),  32'(m_evc));
    check("sat",     32'(sat),     32'(m_sat));
    check("rd_hdr",  32'(rd_hdr),  32'(e_rd[0]));
    check("rd_pld",  32'(rd_pld),  32'(e_rd[1]));
    check("rd_ftr",  32'(rd_ftr),  32'(e_rd[2]));
  endtask

  task automatic do_snap();
    cycle(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic read(input int vc);
    cycle(0, 0, 0, 0, 0, vc, 0);
  endtask

  task automatic check_rd(input string tag, input int h, input int p, input int f);
    check({tag, "_hdr"}, 32'(rd_hdr), 32'(h));
    check({tag, "_pld"}, 32'(rd_pld), 32'(p));
    check({tag, "_ftr"}, 32'(rd_ftr), 32'(f));
  endtask

  // Non-beat cycle: valid without ready, ready without valid, or neither.
  task automatic stall(input bit rnd);
    int x;
    x = $urandom_range(0, 2);
    cycle(x == 0, x == 1, 1'($urandom % 2), int'($urandom % 8),
          rnd && ($urandom % 16 == 0), int'($urandom % 8), rnd && ($urandom % 32 == 0));
  endtask

  task automatic send_pkt(input int vc, input int len, input bit rnd);
    for (int b = 1; b <= len; b++) begin
      if (rnd) repeat ($urandom_range(0, 2)) stall(1);
      cycle(1, 1, b == len, (b == 1) ? vc : int'($urandom % 8),
            rnd && ($urandom % 16 == 0), rnd ? int'($urandom % 8) : 0,
            rnd && ($urandom % 32 == 0));
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_pkt"},  32'(in_pkt),  0);
    check({tag, "_err_len"}, 32'(err_len), 0);
    check({tag, "_err_vc"},  32'(err_vc),  0);
    check({tag, "_sat"},     32'(sat),     0);
    check_rd(tag, 0, 0, 0);
  endtask

  initial begin
    ARESET = 1'b1;
    mon_TVALID = 0; mon_TREADY = 0; mon_TLAST = 0; mon_vc = '0;
    snap_req = 0; rd_vc = '0; err_clr = 0;
    model_reset();
    repeat (2) @(posedge ACLK);
    #1;
    check_all_zero("reset");
    ARESET = 1'b0;

    // 3-beat packet on vc 2
    send_pkt(2, 3, 0);
    do_snap();
    read(2); check_rd("r3pkt_vc2", 1, 1, 1);
    read(1); check_rd("r3pkt_vc1", 0, 0, 0);

    // single-beat packet on vc 0 after 3 cycles of backpressure
    repeat (3) cycle(1, 0, 1, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0, 0);
    do_snap();
    read(0); check_rd("single_vc0", 1, 0, 1);

    // 17-beat packet exceeds MAX_BEATS on its 17th beat
    for (int b = 1; b <= 17; b++) begin
      cycle(1, 1, b == 17, 0, 0, 0, 0);
      if (b == 16) check("len_before", 32'(err_len), 0);
      if (b == 17) check("len_at17", 32'(err_len), 1);
    end
    do_snap();
    read(0); check_rd("long_vc0", 1, 15, 1);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("len_cleared", 32'(err_len), 0);

    // snapshot coincident with a header on vc 3
    do_snap();
    cycle(1, 1, 1, 3, 1, 0, 0);
    read(3); check_rd("snapcoin_a", 0, 0, 0);
    do_snap();
    read(3); check_rd("snapcoin_b", 1, 0, 1);

    // counter saturation with 8-bit counters
    do_snap();
    repeat (256) cycle(1, 1, 1, 1, 0, 0, 0);
    check("sat_set", 32'(sat), 1);
    do_snap();
    read(1); check_rd("sat_vc1", 255, 0, 255);
    cycle(0, 0, 0, 0, 0, 0, 1);
    check("sat_cleared", 32'(sat), 0);

    // illegal VC header: tracked but not counted; out-of-range read is zero
    send_pkt(6, 3, 0);
    check("vc_err_set", 32'(err_vc), 1);
    do_snap();
    read(6); check_rd("badvc_rd", 0, 0, 0);
    check("badvc_idle", 32'(in_pkt), 0);
    cycle(1, 1, 0, 2, 0, 0, 1);
    check("clr_vs_set", 32'(err_vc), 0);
    cycle(1, 1, 1, 0, 0, 0, 0);

    // asynchronous reset in the middle of a vc 1 packet
    do_snap();
    read(1);
    cycle(1, 1, 0, 1, 0, 1, 0);
    cycle(1, 1, 0, 1, 0, 1, 0);
    check("pre_rst_open", 32'(in_pkt), 1);
    #2 ARESET = 1'b1;
    mon_TVALID = 0; mon_TREADY = 0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    cycle(1, 1, 0, 1, 0, 0, 0);
    check("post_rst_hdr", 32'(in_pkt), 1);
    cycle(1, 1, 1, 1, 0, 0, 0);
    do_snap();
    read(1); check_rd("post_rst_vc1", 1, 0, 1);

    // randomized traffic with stalls, snapshots, clears and random readback
    repeat (300) begin
      int vc;
      vc = ($urandom % 8 == 0) ? int'($urandom_range(NUM_VC, 7)) : int'($urandom % NUM_VC);
      send_pkt(vc, int'($urandom_range(1, 20)), 1);
      if ($urandom % 4 == 0) stall(1);
    end
    do_snap();
    for (int i = 0; i < 8; i++) read(i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exanet_axis_vc_monitor.md
EXANET_AXIS_VC_MONITOR -- requirements
Module: exanet_axis_vc_monitor

Interface
REQ-001 Parameter NUM_VC, default 4, number of virtual channels counted (legal 2..16); VC_W = max(1, clog2(NUM_VC)) derived.
REQ-002 Parameter CNT_W, default 32, width of every hdr/pld/ftr counter (legal 8..32).
REQ-003 Parameter MAX_BEATS, default 16, longest legal packet in beats, including header and footer (legal 1..255).
REQ-004 ACLK  input  1  single clock; all logic is on its rising edge.
REQ-005 ARESET  input  1  reset, asynchronous, active-high.
REQ-006 mon_TVALID  input  1  snooped AXIS valid.
REQ-007 mon_TREADY  input  1  snooped AXIS ready; the block never drives the link.
REQ-008 mon_TLAST  input  1  snooped AXIS last.
REQ-009 mon_vc  input  VC_W  VC of the packet, meaningful on header beat only.
REQ-010 snap_req  input  1  one-cycle pulse: snapshot all live counters and clear them.
REQ-011 rd_vc  input  VC_W  snapshot VC to read.
REQ-012 rd_hdr / rd_pld / rd_ftr  output  CNT_W each  snapshot counters of rd_vc.
REQ-013 err_clr  input  1  clears all sticky error flags.
REQ-014 err_len  output  1  sticky: a packet exceeded MAX_BEATS.
REQ-015 err_vc  output  1  sticky: a header carried mon_vc >= NUM_VC.
REQ-016 sat  output  1  sticky: some live counter saturated.
REQ-017 in_pkt  output  1  high while a packet is open (state IN_PKT).

Function
REQ-018 Beat = cycle with mon_TVALID & mon_TREADY; nothing else counts.
REQ-019 FSM states IDLE and IN_PKT; IDLE->IN_PKT on a beat with TLAST=0; IN_PKT->IDLE on a beat with TLAST=1; any other case holds state.
REQ-020 Beat in IDLE is a header: latches mon_vc into cur_vc, increments hdr[mon_vc]; if TLAST=1 it also increments ftr[mon_vc] (single-beat packet, no pld count).
REQ-021 Beat in IN_PKT with TLAST=0 increments pld[cur_vc]; with TLAST=1 increments ftr[cur_vc].
REQ-022 Beat counter resets to 1 on header, increments per beat in IN_PKT, and saturates at 255; err_len sets on the beat where the count would exceed MAX_BEATS; the packet continues to be counted normally.
REQ-023 Header with mon_vc >= NUM_VC sets err_vc; that packet's beats update no counter but the FSM still tracks it.
REQ-024 Live counters saturate at all-ones (no wrap); an increment attempted at all-ones sets sat.
REQ-025 On snap_req, every live counter is copied into its snapshot register and the live counter is cleared in the same edge; a beat in that cycle counts into the new epoch (live value becomes 1, snapshot excludes it).
REQ-026 snap_req does not affect FSM state, cur_vc or beat count; a packet spanning a snapshot is split across epochs.
REQ-027 rd_hdr/rd_pld/rd_ftr are registered: value for rd_vc presented at edge N appears after edge N+1 (1-cycle latency); rd_vc >= NUM_VC reads zero.
REQ-028 err_clr clears err_len, err_vc and sat; a set event in the same cycle wins (flag stays 1).
REQ-029 Output in_pkt is the registered FSM state, high the cycle after the opening header.

Reset
REQ-030 ARESET asserts asynchronously: FSM to IDLE, cur_vc 0, beat count 0, all live and snapshot counters 0, rd_* 0, err_len/err_vc/sat/in_pkt 0.
REQ-031 Reset mid-packet discards the open packet; the first beat after release is treated as a header.
REQ-032 Deassertion is synchronous to ACLK by the integrating system; no beat is counted in the release cycle's preceding edge.

Verification
REQ-033 NUM_VC=4: 3-beat packet on vc 2, snap_req, rd_vc=2 -> rd_hdr=1, rd_pld=1, rd_ftr=1; rd_vc=1 -> all 0.
REQ-034 Single-beat packet on vc 0, TVALID high with TREADY low for 3 cycles first -> after snap hdr[0]=1, pld[0]=0, ftr[0]=1.
REQ-035 MAX_BEATS=16: 17-beat packet -> err_len rises on 17th beat, pld counts 15; err_clr -> err_len 0.
REQ-036 CNT_W=8: 256 single-beat packets on vc 1 -> hdr[1]=255 after snap, sat=1.
REQ-037 snap_req coincident with a header on vc 3 -> snapshot hdr[3] excludes it; next snap gives hdr[3]=1.
REQ-038 ARESET pulsed mid-packet (vc 1, 2 beats in) -> in_pkt 0 immediately, all outputs 0; next beat counted as header.
